// File: rtl/ysyx_axi_pkg.sv
// ysyx_axi_pkg
// Shared definitions for the AXI4 default slave:
//   - AXI response codes
//   - read / write FSM state encodings
//   - AXI4 burst-length field width
package ysyx_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Width of the AXI4 AxLEN field (bursts of 1..256 beats)
  localparam int AXI_LEN_W = 8;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

endpackage

// File: rtl/ysyx_axi_default_slave.sv
// ysyx_axi_default_slave
// AXI4 default slave: accepts every request on the SoC slave port, echoes the
// ID and answers every beat with RESP_CODE so that no master access can hang.
// Every accepted address handshake is counted (saturating) and the address is
// logged for software diagnosis.
//
// Ports
//   clock, reset            : clock (rising edge), synchronous active-high reset
//   io_slave_ar*            : AXI4 read-address channel (arready is an output)
//   io_slave_r*             : AXI4 read-data channel (rready is an input)
//   io_slave_aw*            : AXI4 write-address channel (awready is an output)
//   io_slave_w*             : AXI4 write-data channel (wready is an output)
//   io_slave_b*             : AXI4 write-response channel (bready is an input)
//   err_count               : saturating count of AR + AW handshakes
//   err_addr                : address of the most recent handshake (AW wins ties)
//   err_pulse               : one-cycle pulse the cycle after any handshake
//
// CNT_W must be at least 2 so a dual handshake (+2) is representable.
module ysyx_axi_default_slave
  import ysyx_axi_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 64,
  parameter int          ID_W       = 4,
  parameter logic [1:0]  RESP_CODE  = AXI_RESP_DECERR,
  parameter logic [63:0] RDATA_FILL = 64'd0,
  parameter int          CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  // read address
  input  logic                  io_slave_arvalid,
  output logic                  io_slave_arready,
  input  logic [ADDR_W-1:0]     io_slave_araddr,
  input  logic [ID_W-1:0]       io_slave_arid,
  input  logic [7:0]            io_slave_arlen,
  input  logic [2:0]            io_slave_arsize,
  input  logic [1:0]            io_slave_arburst,
  // read data
  output logic                  io_slave_rvalid,
  input  logic                  io_slave_rready,
  output logic [1:0]            io_slave_rresp,
  output logic [DATA_W-1:0]     io_slave_rdata,
  output logic                  io_slave_rlast,
  output logic [ID_W-1:0]       io_slave_rid,
  // write address
  input  logic                  io_slave_awvalid,
  output logic                  io_slave_awready,
  input  logic [ADDR_W-1:0]     io_slave_awaddr,
  input  logic [ID_W-1:0]       io_slave_awid,
  input  logic [7:0]            io_slave_awlen,
  input  logic [2:0]            io_slave_awsize,
  input  logic [1:0]            io_slave_awburst,
  // write data
  input  logic                  io_slave_wvalid,
  output logic                  io_slave_wready,
  input  logic [DATA_W-1:0]     io_slave_wdata,
  input  logic [DATA_W/8-1:0]   io_slave_wstrb,
  input  logic                  io_slave_wlast,
  // write response
  output logic                  io_slave_bvalid,
  input  logic                  io_slave_bready,
  output logic [1:0]            io_slave_bresp,
  output logic [ID_W-1:0]       io_slave_bid,
  // error log
  output logic [CNT_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     err_addr,
  output logic                  err_pulse
);

  // Replicate the 64-bit fill pattern across DATA_W (truncates when narrower)
  function automatic logic [DATA_W-1:0] fill_data(input logic [63:0] pat);
    logic [DATA_W-1:0] f;
    f = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      f[i] = pat[i % 64];
    end
    return f;
  endfunction

  localparam logic [DATA_W-1:0] FILL_WORD = fill_data(RDATA_FILL);

  // Payload fields and burst attributes this slave never looks at
  logic unused_inputs_s;
  assign unused_inputs_s = ^{io_slave_arsize, io_slave_arburst, io_slave_awlen,
                             io_slave_awsize, io_slave_awburst, io_slave_wdata,
                             io_slave_wstrb};

  // ---------------------------------------------------------------- state
  r_state_e               r_state_q, r_state_d;
  logic [AXI_LEN_W-1:0]   r_cnt_q,   r_cnt_d;
  logic [ID_W-1:0]        r_id_q,    r_id_d;
  logic [DATA_W-1:0]      rdata_q,   rdata_d;
  logic [1:0]             rresp_q,   rresp_d;

  w_state_e               w_state_q, w_state_d;
  logic [ID_W-1:0]        b_id_q,    b_id_d;
  logic [1:0]             bresp_q,   bresp_d;

  logic [CNT_W-1:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0]      err_addr_q,  err_addr_d;
  logic                   err_pulse_q, err_pulse_d;

  // Handshake decodes; ready terms come from state only
  logic ar_hs_s, r_hs_s, r_last_s, aw_hs_s, w_last_hs_s, b_hs_s;
  assign ar_hs_s     = io_slave_arvalid & (r_state_q == R_IDLE);
  assign r_hs_s      = io_slave_rready  & (r_state_q == R_DATA);
  assign r_last_s    = (r_cnt_q == {AXI_LEN_W{1'b0}});
  assign aw_hs_s     = io_slave_awvalid & (w_state_q == W_IDLE);
  assign w_last_hs_s = io_slave_wvalid & io_slave_wlast & (w_state_q == W_DATA);
  assign b_hs_s      = io_slave_bready  & (w_state_q == W_RESP);

  // State and datapath registers, synchronous reset clears everything
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q   <= R_IDLE;
      r_cnt_q     <= {AXI_LEN_W{1'b0}};
      r_id_q      <= {ID_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      rresp_q     <= 2'b00;
      w_state_q   <= W_IDLE;
      b_id_q      <= {ID_W{1'b0}};
      bresp_q     <= 2'b00;
      err_count_q <= {CNT_W{1'b0}};
      err_addr_q  <= {ADDR_W{1'b0}};
      err_pulse_q <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      r_cnt_q     <= r_cnt_d;
      r_id_q      <= r_id_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      w_state_q   <= w_state_d;
      b_id_q      <= b_id_d;
      bresp_q     <= bresp_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // ------------------------------------------------------------- read FSM
  // Read next-state: one AR, then arlen+1 beats until the rlast handshake
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) r_state_d = R_DATA;
        else         r_state_d = R_IDLE;
      end
      R_DATA: begin
        if (r_hs_s && r_last_s) r_state_d = R_IDLE;
        else                    r_state_d = R_DATA;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read payload: latched at AR so it stays stable while rvalid is stalled
  always_comb begin
    r_cnt_d = r_cnt_q;
    r_id_d  = r_id_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs_s) begin
      r_cnt_d = io_slave_arlen;
      r_id_d  = io_slave_arid;
      rdata_d = FILL_WORD;
      rresp_d = RESP_CODE;
    end else if (r_hs_s && !r_last_s) begin
      r_cnt_d = r_cnt_q - {{(AXI_LEN_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt_d = r_cnt_q;
    end
  end

  // Read outputs decoded from state
  always_comb begin
    io_slave_arready = 1'b0;
    io_slave_rvalid  = 1'b0;
    io_slave_rlast   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        io_slave_arready = 1'b1;
      end
      R_DATA: begin
        io_slave_rvalid = 1'b1;
        io_slave_rlast  = r_last_s;
      end
      default: begin
        io_slave_arready = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------ write FSM
  // Write next-state: AW first, W beats until wlast, then a single B
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) w_state_d = W_DATA;
        else         w_state_d = W_IDLE;
      end
      W_DATA: begin
        if (w_last_hs_s) w_state_d = W_RESP;
        else             w_state_d = W_DATA;
      end
      W_RESP: begin
        if (b_hs_s) w_state_d = W_IDLE;
        else        w_state_d = W_RESP;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write response payload latched at AW
  always_comb begin
    b_id_d  = b_id_q;
    bresp_d = bresp_q;
    if (aw_hs_s) begin
      b_id_d  = io_slave_awid;
      bresp_d = RESP_CODE;
    end else begin
      b_id_d  = b_id_q;
      bresp_d = bresp_q;
    end
  end

  // Write outputs decoded from state; wready stays low until AW is taken
  always_comb begin
    io_slave_awready = 1'b0;
    io_slave_wready  = 1'b0;
    io_slave_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE:  io_slave_awready = 1'b1;
      W_DATA:  io_slave_wready  = 1'b1;
      W_RESP:  io_slave_bvalid  = 1'b1;
      default: io_slave_awready = 1'b0;
    endcase
  end

  // ------------------------------------------------------------ error log
  logic [1:0]     inc_s;
  logic [CNT_W:0] sum_s;
  assign inc_s = {1'b0, ar_hs_s} + {1'b0, aw_hs_s};
  assign sum_s = {1'b0, err_count_q} + {{(CNT_W-1){1'b0}}, inc_s};

  // Saturating counter (extra carry bit detects overflow); AW address wins ties
  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    err_pulse_d = ar_hs_s | aw_hs_s;
    if (sum_s[CNT_W]) err_count_d = {CNT_W{1'b1}};
    else              err_count_d = sum_s[CNT_W-1:0];
    if (aw_hs_s)      err_addr_d = io_slave_awaddr;
    else if (ar_hs_s) err_addr_d = io_slave_araddr;
    else              err_addr_d = err_addr_q;
  end

  assign io_slave_rid   = r_id_q;
  assign io_slave_rdata = rdata_q;
  assign io_slave_rresp = rresp_q;
  assign io_slave_bid   = b_id_q;
  assign io_slave_bresp = bresp_q;
  assign err_count      = err_count_q;
  assign err_addr       = err_addr_q;
  assign err_pulse      = err_pulse_q;

endmodule

// File: tb/tb_ysyx_axi_default_slave.sv
// Directed bench for ysyx_axi_default_slave. Expected R and B beats are
// pushed into queues when requests are issued and popped when the DUT
// handshakes them. A second instance with CNT_W=2 shares all inputs and is
// used for the counter saturation case.
module tb_ysyx_axi_default_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [63:0] wdata;
  logic [7:0]  wstrb;

  logic        arready, rvalid, rlast, awready, wready, bvalid, err_pulse;
  logic [1:0]  rresp, bresp;
  logic [63:0] rdata;
  logic [3:0]  rid, bid;
  logic [15:0] err_count;
  logic [31:0] err_addr;

  logic        s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid, s_err_pulse;
  logic [1:0]  s_rresp, s_bresp, s_err_count;
  logic [63:0] s_rdata;
  logic [3:0]  s_rid, s_bid;
  logic [31:0] s_err_addr;

  ysyx_axi_default_slave dut (
    .clock(clk), .reset(reset),
    .io_slave_arvalid(arvalid), .io_slave_arready(arready), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
    .io_slave_arburst(arburst),
    .io_slave_rvalid(rvalid), .io_slave_rready(rready), .io_slave_rresp(rresp),
    .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid),
    .io_slave_awvalid(awvalid), .io_slave_awready(awready), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst),
    .io_slave_wvalid(wvalid), .io_slave_wready(wready), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bvalid(bvalid), .io_slave_bready(bready), .io_slave_bresp(bresp),
    .io_slave_bid(bid),
    .err_count(err_count), .err_addr(err_addr), .err_pulse(err_pulse)
  );

  ysyx_axi_default_slave #(.CNT_W(2)) dut_sat (
    .clock(clk), .reset(reset),
    .io_slave_arvalid(arvalid), .io_slave_arready(s_arready), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
    .io_slave_arburst(arburst),
    .io_slave_rvalid(s_rvalid), .io_slave_rready(rready), .io_slave_rresp(s_rresp),
    .io_slave_rdata(s_rdata), .io_slave_rlast(s_rlast), .io_slave_rid(s_rid),
    .io_slave_awvalid(awvalid), .io_slave_awready(s_awready), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst),
    .io_slave_wvalid(wvalid), .io_slave_wready(s_wready), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bvalid(s_bvalid), .io_slave_bready(bready), .io_slave_bresp(s_bresp),
    .io_slave_bid(s_bid),
    .err_count(s_err_count), .err_addr(s_err_addr), .err_pulse(s_err_pulse)
  );

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic [63:0] data;
  } r_exp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t r_q[$];
  b_exp_t b_q[$];

  int n_cmp = 0;
  int n_mis = 0;

  logic       r_hold = 1'b0;
  logic [3:0] r_hold_id;
  logic       b_hold = 1'b0;
  logic [3:0] b_hold_id;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_read(input logic [3:0] id, input int len);
    r_exp_t e;
    for (int i = 0; i <= len; i++) begin
      e.id = id; e.resp = 2'b11; e.last = (i == len); e.data = 64'd0;
      r_q.push_back(e);
    end
  endtask

  task automatic push_b(input logic [3:0] id);
    b_exp_t e;
    e.id = id; e.resp = 2'b11;
    b_q.push_back(e);
  endtask

  // One clock: monitor at the falling edge, return #1 after the rising edge
  task automatic step();
    r_exp_t re;
    b_exp_t be;
    @(negedge clk);
    if (rvalid && rready) begin
      if (r_q.size() == 0) chk("r_unexpected_beat", 64'd1, 64'd0);
      else begin
        re = r_q.pop_front();
        chk("rid", {60'd0, rid}, {60'd0, re.id});
        chk("rresp", {62'd0, rresp}, {62'd0, re.resp});
        chk("rlast", {63'd0, rlast}, {63'd0, re.last});
        chk("rdata", rdata, re.data);
      end
    end
    if (rvalid) chk("arready_in_burst", {63'd0, arready}, 64'd0);
    if (r_hold) begin
      chk("r_stall_valid", {63'd0, rvalid}, 64'd1);
      chk("r_stall_id", {60'd0, rid}, {60'd0, r_hold_id});
    end
    r_hold = rvalid && !rready;
    r_hold_id = rid;
    if (bvalid && bready) begin
      if (b_q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
      else begin
        be = b_q.pop_front();
        chk("bid", {60'd0, bid}, {60'd0, be.id});
        chk("bresp", {62'd0, bresp}, {62'd0, be.resp});
      end
    end
    if (b_hold) begin
      chk("b_stall_valid", {63'd0, bvalid}, 64'd1);
      chk("b_stall_id", {60'd0, bid}, {60'd0, b_hold_id});
    end
    b_hold = bvalid && !bready;
    b_hold_id = bid;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    arvalid = 1'b0; araddr = 32'd0; arid = 4'd0; arlen = 8'd0; arsize = 3'd3; arburst = 2'd1;
    awvalid = 1'b0; awaddr = 32'd0; awid = 4'd0; awlen = 8'd0; awsize = 3'd3; awburst = 2'd1;
    wvalid = 1'b0; wlast = 1'b0; wdata = 64'd0; wstrb = 8'hFF;
    rready = 1'b0; bready = 1'b0;
    @(posedge clk); #1;
    step();

    // reset state
    chk("rst_arready", {63'd0, arready}, 64'd1);
    chk("rst_awready", {63'd0, awready}, 64'd1);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_wready", {63'd0, wready}, 64'd0);
    chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
    chk("rst_rlast", {63'd0, rlast}, 64'd0);
    chk("rst_err_count", {48'd0, err_count}, 64'd0);
    chk("rst_err_addr", {32'd0, err_addr}, 64'd0);
    chk("rst_err_pulse", {63'd0, err_pulse}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_bid", {60'd0, bid}, 64'd0);
    reset = 1'b0;
    step();

    // single read
    arvalid = 1'b1; araddr = 32'h8000_0000; arid = 4'd5; arlen = 8'd0; rready = 1'b1;
    push_read(4'd5, 0);
    step();
    arvalid = 1'b0;
    chk("t1_rvalid", {63'd0, rvalid}, 64'd1);
    chk("t1_rlast", {63'd0, rlast}, 64'd1);
    chk("t1_err_count", {48'd0, err_count}, 64'd1);
    chk("t1_err_addr", {32'd0, err_addr}, 64'h8000_0000);
    chk("t1_err_pulse", {63'd0, err_pulse}, 64'd1);
    step();
    chk("t1_rvalid_done", {63'd0, rvalid}, 64'd0);
    chk("t1_arready_back", {63'd0, arready}, 64'd1);
    chk("t1_err_pulse_low", {63'd0, err_pulse}, 64'd0);

    // burst read, rready toggling
    arvalid = 1'b1; araddr = 32'h0000_0100; arid = 4'd3; arlen = 8'd7; rready = 1'b0;
    push_read(4'd3, 7);
    step();
    arvalid = 1'b0;
    chk("t2_first_rvalid", {63'd0, rvalid}, 64'd1);
    for (int c = 0; c < 40 && (r_q.size() != 0 || rvalid); c++) begin
      rready = c[0];
      step();
    end
    chk("t2_beats_left", r_q.size(), 64'd0);
    chk("t2_arready_back", {63'd0, arready}, 64'd1);
    chk("t2_err_count", {48'd0, err_count}, 64'd2);
    rready = 1'b1;

    // write burst with B backpressure
    awvalid = 1'b1; awaddr = 32'h0000_3000; awid = 4'd9; awlen = 8'd3;
    push_b(4'd9);
    step();
    awvalid = 1'b0;
    chk("t3_wready", {63'd0, wready}, 64'd1);
    chk("t3_awready", {63'd0, awready}, 64'd0);
    chk("t3_err_count", {48'd0, err_count}, 64'd3);
    chk("t3_err_addr", {32'd0, err_addr}, 64'h3000);
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; wlast = (i == 3); wdata = {$urandom(), $urandom()};
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("t3_bvalid", {63'd0, bvalid}, 64'd1);
    chk("t3_wready_off", {63'd0, wready}, 64'd0);
    for (int i = 0; i < 3; i++) step();
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("t3_bvalid_done", {63'd0, bvalid}, 64'd0);
    chk("t3_awready_back", {63'd0, awready}, 64'd1);

    // W before AW
    wvalid = 1'b1; wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_wready_wait", {63'd0, wready}, 64'd0);
      step();
    end
    awvalid = 1'b1; awaddr = 32'h0000_4000; awid = 4'd2;
    push_b(4'd2);
    chk("t4_wready_at_aw", {63'd0, wready}, 64'd0);
    step();
    awvalid = 1'b0;
    chk("t4_wready_after_aw", {63'd0, wready}, 64'd1);
    step();
    wvalid = 1'b0; wlast = 1'b0;
    chk("t4_bvalid", {63'd0, bvalid}, 64'd1);
    bready = 1'b1;
    step();
    chk("t4_bvalid_done", {63'd0, bvalid}, 64'd0);
    step();
    bready = 1'b0;
    chk("t4_single_b", {63'd0, bvalid}, 64'd0);
    chk("t4_b_queue", b_q.size(), 64'd0);

    // AR and AW in the same cycle
    arvalid = 1'b1; araddr = 32'h0000_1000; arid = 4'd1; arlen = 8'd1;
    awvalid = 1'b1; awaddr = 32'h0000_2000; awid = 4'd4;
    rready = 1'b1;
    push_read(4'd1, 1);
    push_b(4'd4);
    step();
    arvalid = 1'b0; awvalid = 1'b0;
    chk("t5_err_count", {48'd0, err_count}, 64'd6);
    chk("t5_err_addr", {32'd0, err_addr}, 64'h2000);
    chk("t5_err_pulse", {63'd0, err_pulse}, 64'd1);
    chk("t5_sat_count", {62'd0, s_err_count}, 64'd3);
    wvalid = 1'b1; wlast = 1'b1; bready = 1'b1;
    for (int c = 0; c < 20 && (r_q.size() != 0 || b_q.size() != 0 || rvalid || bvalid); c++) begin
      step();
      if (!wready) begin wvalid = 1'b0; wlast = 1'b0; end
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    chk("t5_r_left", r_q.size(), 64'd0);
    chk("t5_b_left", b_q.size(), 64'd0);
    chk("t5_arready", {63'd0, arready}, 64'd1);
    chk("t5_awready", {63'd0, awready}, 64'd1);

    // saturation with CNT_W=2
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_count", {48'd0, err_count}, 64'd0);
    chk("t6_rst_sat_count", {62'd0, s_err_count}, 64'd0);
    for (int n = 0; n < 5; n++) begin
      arvalid = 1'b1; araddr = 32'h0000_5000 + 32'(n); arid = 4'(n); arlen = 8'd0;
      push_read(4'(n), 0);
      step();
      arvalid = 1'b0;
      step();
      if (n == 1) chk("t6_sat_two", {62'd0, s_err_count}, 64'd2);
    end
    chk("t6_sat_count", {62'd0, s_err_count}, 64'd3);
    chk("t6_full_count", {48'd0, err_count}, 64'd5);
    chk("t6_err_addr", {32'd0, err_addr}, 64'h5004);

    // reset in the middle of a burst
    arvalid = 1'b1; araddr = 32'h0000_6000; arid = 4'd7; arlen = 8'd15;
    push_read(4'd7, 15);
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t7_mid_rvalid", {63'd0, rvalid}, 64'd1);
    rready = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    r_q.delete();
    r_hold = 1'b0;
    chk("t7_rvalid", {63'd0, rvalid}, 64'd0);
    chk("t7_arready", {63'd0, arready}, 64'd1);
    chk("t7_err_count", {48'd0, err_count}, 64'd0);
    chk("t7_rlast", {63'd0, rlast}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
